stat_dump: RTL

- Reader side of the statistics accumulator RAM.
- On request it swaps the accumulator's working block and waits for in-flight accumulate writes to drain.
- It then reads every word of the now-idle block, streams it out over a valid/ready word interface, and zeroes each word once it has been accepted.
- Sits between StatCollect's internal RAM port (ram_addr/ram_data/ram_cs/ram_we, 512x32, two 256-word blocks) and the host-side upload FIFO.

---
 rtl/stat_pkg.sv | 23 ++
 rtl/stat_dump_if.sv | 14 +
 rtl/stat_dump.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/stat_pkg.sv
// Shared types and constants for the statistics RAM dump path.
// Imported by the dump interface and the dump controller.
package stat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWAP,
        ST_SETTLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_OUT,
        ST_CLR,
        ST_DONE
    } stat_state_e;

    localparam int         STAT_NBINS        = 240;
    localparam int         STAT_BLK_WORDS    = 256;
    localparam logic [7:0] STAT_SEMI_OVF_IDX = 8'hf4;
    localparam logic [7:0] STAT_OVF_IDX      = 8'hfc;
    localparam int         STAT_ADDR_W       = 9;
    localparam int         STAT_DATA_W       = 32;

endpackage

// File: rtl/stat_dump_if.sv
// Valid/ready word stream carrying dumped statistics words and their index.
// The dump controller drives the master side, the upload FIFO the slave side.
interface stat_dump_if;
    import stat_pkg::*;

    logic [STAT_DATA_W-1:0] dout;
    logic [7:0]             dout_idx;
    logic                   dout_valid;
    logic                   dout_ready;

    modport master (output dout, output dout_idx, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_idx, input dout_valid, output dout_ready);

endinterface

// File: rtl/stat_dump.sv
// Reader side of the statistics accumulator RAM: swaps the working block,
// waits for the collector to drain, then streams and clears the idle block.
module stat_dump
    import stat_pkg::*;
#(
    parameter int RD_LAT        = 1,
    parameter int SETTLE_CYCLES = 16,
    parameter int NWORDS        = 256,
    parameter int CLEAR_ON_READ = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    output logic                   ram_blk_sel_o,
    output logic [STAT_ADDR_W-1:0] ram_addr_o,
    output logic [STAT_DATA_W-1:0] ram_data_o,
    output logic                   ram_cs_o,
    output logic                   ram_we_o,
    input  logic [STAT_DATA_W-1:0] ram_data_i,
    stat_dump_if.master            dout_if,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   ovf_o,
    output logic                   semi_ovf_o
);

    localparam int              SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]      LAT_LOAD    = 2'(RD_LAT - 1);
    localparam logic [7:0]      LAST_IDX    = 8'(NWORDS - 1);

    stat_state_e             state_q;
    logic                    blk_sel_q;
    logic                    dump_blk_q;
    logic [7:0]              idx_q;
    logic [SETTLE_W-1:0]     settle_q;
    logic [1:0]              lat_q;
    logic [STAT_ADDR_W-1:0]  addr_q;
    logic                    cs_q;
    logic                    we_q;
    logic [STAT_DATA_W-1:0]  dout_q;
    logic [7:0]              dout_idx_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    ovf_q;
    logic                    semi_ovf_q;

    logic                    idx_last;
    logic [7:0]              idx_nxt;

    assign idx_last = (idx_q == LAST_IDX);
    assign idx_nxt  = idx_q + 8'd1;

    // All RAM and stream outputs are registered; each transition sets up the
    // strobes for the state being entered, so cs/we default low every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            blk_sel_q  <= 1'b0;
            dump_blk_q <= 1'b0;
            idx_q      <= '0;
            settle_q   <= '0;
            lat_q      <= '0;
            addr_q     <= '0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            dout_q     <= '0;
            dout_idx_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            semi_ovf_q <= 1'b0;
        end else begin
            cs_q   <= 1'b0;
            we_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        dump_blk_q <= blk_sel_q;
                        ovf_q      <= 1'b0;
                        semi_ovf_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    blk_sel_q <= ~blk_sel_q;
                    idx_q     <= '0;
                    settle_q  <= SETTLE_LOAD;
                    state_q   <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_q == '0) begin
                        cs_q    <= 1'b1;
                        addr_q  <= {dump_blk_q, idx_q};
                        state_q <= ST_RD_REQ;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                ST_RD_REQ: begin
                    lat_q   <= LAT_LOAD;
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (lat_q == '0) begin
                        dout_q     <= ram_data_i;
                        dout_idx_q <= idx_q;
                        valid_q    <= 1'b1;
                        state_q    <= ST_OUT;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                ST_OUT: begin
                    if (dout_if.dout_ready) begin
                        valid_q <= 1'b0;
                        if (dout_idx_q == STAT_SEMI_OVF_IDX && dout_q != '0) semi_ovf_q <= 1'b1;
                        if (dout_idx_q == STAT_OVF_IDX && dout_q != '0)      ovf_q      <= 1'b1;
                        if (CLEAR_ON_READ != 0) begin
                            cs_q    <= 1'b1;
                            we_q    <= 1'b1;
                            addr_q  <= {dump_blk_q, idx_q};
                            state_q <= ST_CLR;
                        end else if (idx_last) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q   <= idx_nxt;
                            cs_q    <= 1'b1;
                            addr_q  <= {dump_blk_q, idx_nxt};
                            state_q <= ST_RD_REQ;
                        end
                    end
                end
                ST_CLR: begin
                    if (idx_last) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q   <= idx_nxt;
                        cs_q    <= 1'b1;
                        addr_q  <= {dump_blk_q, idx_nxt};
                        state_q <= ST_RD_REQ;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ram_blk_sel_o      = blk_sel_q;
    assign ram_addr_o         = addr_q;
    assign ram_data_o         = '0;
    assign ram_cs_o           = cs_q;
    assign ram_we_o           = we_q;
    assign dout_if.dout       = dout_q;
    assign dout_if.dout_idx   = dout_idx_q;
    assign dout_if.dout_valid = valid_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign ovf_o              = ovf_q;
    assign semi_ovf_o         = semi_ovf_q;

endmodule
